fifo_rd_serializer: RTL and testbench
=====================================

FIFO_RD_SERIALIZER -- requirements
Module: fifo_rd_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: output byte-lane width in bits.
REQ-002 Parameter WORD_WIDTH, default 32: FIFO word width; SHALL be an integer multiple of DATA_WIDTH, giving LANES = WORD_WIDTH/DATA_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 16: width of the word-count status counter.
REQ-004 clk  input  1  Single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  Asynchronous, active-low reset.
REQ-006 fifo_empty  input  1  Lookahead FIFO empty flag; fifo_dout is valid whenever it is low.
REQ-007 fifo_dout  input  WORD_WIDTH  Lookahead FIFO head word.
REQ-008 fifo_rd  output  1  Pop strobe to the FIFO; one pop per high cycle.
REQ-009 clr  input  1  Synchronous flush; discards the held word.
REQ-010 m_valid  output  1  Output byte valid.
REQ-011 m_ready  input  1  Downstream ready.
REQ-012 m_data  output  DATA_WIDTH  Output byte.
REQ-013 m_last  output  1  High with the final byte of a word.
REQ-014 word_cnt  output  CNT_WIDTH  Count of words fully emitted.

Function
REQ-015 The block SHALL have two states: IDLE (no word held) and SHIFT (word held in the shift register).
REQ-016 fifo_rd SHALL be combinational: it is high iff !fifo_empty && !clr && (state==IDLE || (m_valid && m_ready && m_last)).
REQ-017 fifo_rd SHALL never be high while fifo_empty is high.
REQ-018 On a cycle with fifo_rd high, the shift register SHALL load fifo_dout, the lane index SHALL reset to 0, and the state SHALL be SHIFT on the next cycle.
REQ-019 Bytes SHALL be emitted least-significant lane first: m_data = shift register bits [DATA_WIDTH-1:0].
REQ-020 m_valid SHALL equal (state==SHIFT), and m_data SHALL be driven from registers only.
REQ-021 m_last SHALL be high iff state==SHIFT && lane index == LANES-1.
REQ-022 On an m_valid && m_ready cycle with m_last low, the register SHALL shift right by DATA_WIDTH and the lane index SHALL increment.
REQ-023 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-024 On an m_valid && m_ready && m_last cycle, the state SHALL go to SHIFT with a new word if fifo_rd is high, and to IDLE otherwise; this gives zero bubble between words.
REQ-025 word_cnt SHALL increment on every m_valid && m_ready && m_last cycle, and SHALL wrap modulo 2^CNT_WIDTH.
REQ-026 Pop-to-first-byte latency SHALL be 1 cycle; throughput SHALL be 1 byte per cycle while m_ready is high.
REQ-027 clr high SHALL force the state to IDLE and the lane index to 0 on the next edge, suppressing fifo_rd and the word_cnt increment in that cycle.
REQ-028 clr SHALL have priority over a simultaneous final-byte handshake.
REQ-029 clr SHALL NOT reset word_cnt.
REQ-030 If LANES==1, every byte SHALL be marked m_last, and the block SHALL act as a registered FIFO-to-stream adapter.

Reset
REQ-031 While rst_n is low, the following SHALL be forced asynchronously: state=IDLE, lane index=0, shift register=0, word_cnt=0, m_valid=0, m_last=0, m_data=0.
REQ-032 fifo_rd SHALL be 0 while rst_n is low.
REQ-033 Reset deassertion SHALL take effect at the first rising edge after rst_n goes high.
REQ-034 A reset asserted mid-word SHALL drop the remaining bytes, and no partial word SHALL be counted.

Verification
REQ-035 Single word: FIFO holds 0xC409F65A, m_ready=1 -> fifo_rd high for 1 cycle, then m_data 5A,F6,09,C4 on 4 consecutive cycles; m_last on C4 only; word_cnt=1.
REQ-036 Back-to-back words: FIFO holds 0xC409F65A, then 0x7AA0E281, m_ready=1 -> 8 consecutive bytes 5A,F6,09,C4,81,E2,A0,7A with no gap; second fifo_rd coincides with the C4 handshake; word_cnt=2.
REQ-037 Backpressure: random m_ready (50%) over 1024 random words -> output byte sequence equals the little-endian expansion of the input; m_data is stable during stalls; word_cnt=1024.
REQ-038 Empty FIFO: fifo_empty=1 for 20 cycles -> fifo_rd=0 and m_valid=0 throughout; first byte appears 1 cycle after fifo_empty falls.
REQ-039 clr mid-word: clr pulsed after byte F6 is accepted -> no further bytes of that word; the next pop starts a fresh word at lane 0; word_cnt unchanged.
REQ-040 Async reset mid-word: rst_n pulled low between edges after byte 09 -> m_valid falls immediately without waiting for a clock edge; word_cnt=0; after release, the next word emits from lane 0.

Source files
------------

// File: rtl/fifo_rd_serializer.sv
// Pops words from a lookahead FIFO and emits them as a stream of byte lanes,
// least-significant lane first, with zero bubble between consecutive words.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no word held, waiting for the FIFO
// SHIFT | word held, current lane presented on m_data
module fifo_rd_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  input  logic                  clr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int LANES  = WORD_WIDTH / DATA_WIDTH;
  // Keep the lane index at least one bit wide so LANES==1 still elaborates.
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q;
  logic [LANE_W-1:0]      lane_q;
  logic [WORD_WIDTH-1:0]  shift_q;
  logic [CNT_WIDTH-1:0]   word_cnt_q;
  logic [CNT_WIDTH-1:0]   word_cnt_d;
  logic                   hs;
  logic                   hs_last;

  // Outputs come straight from state, lane and shift registers.
  assign m_valid  = (state_q == SHIFT);
  assign m_last   = m_valid && (lane_q == LAST_LANE);
  assign m_data   = shift_q[DATA_WIDTH-1:0];
  assign word_cnt = word_cnt_q;

  assign hs      = m_valid && m_ready;
  assign hs_last = hs && m_last;

  // Pop when empty-handed, or in the same cycle the final lane is accepted.
  // rst_n gating keeps the FIFO untouched while the block is held in reset.
  assign fifo_rd = rst_n && !fifo_empty && !clr && ((state_q == IDLE) || hs_last);

  // Count completed words; a flushed word never counts.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (hs_last && !clr) begin
      word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Serializer FSM: load on pop, shift on accepted non-final lane, flush on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      if (clr) begin
        state_q <= IDLE;
        lane_q  <= '0;
      end else if (fifo_rd) begin
        state_q <= SHIFT;
        lane_q  <= '0;
        shift_q <= fifo_dout;
      end else if (hs) begin
        if (m_last) begin
          state_q <= IDLE;
        end else begin
          lane_q  <= lane_q + LANE_W'(1);
          shift_q <= shift_q >> DATA_WIDTH;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: directed scenarios plus a randomized
// backpressure run, all checked against a word/byte-level reference.
module tb_fifo_rd_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd;
  logic        clr = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] word_cnt;

  fifo_rd_serializer #(.DATA_WIDTH(8), .WORD_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .clr        (clr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] fq[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  out_bytes[$];

  // Reference: is a word held, which byte of it is next, how many words done.
  bit          mdl_busy = 1'b0;
  int          mdl_pos = 0;
  logic [31:0] mdl_word = '0;
  int          mdl_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, check at negedge+1, advance the reference.
  task automatic step(input bit rdy, input bit c);
    bit exp_last;
    bit exp_rd;
    bit hs;
    @(negedge clk);
    m_ready    = rdy;
    clr        = c;
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : $urandom;
    #1;
    exp_last = mdl_busy && (mdl_pos == 3);
    hs       = mdl_busy && rdy;
    exp_rd   = (fq.size() != 0) && !c && (!mdl_busy || (hs && exp_last));
    chk("m_valid", m_valid, mdl_busy);
    chk("fifo_rd", fifo_rd, exp_rd);
    chk("m_last", m_last, exp_last);
    chk("word_cnt", word_cnt, mdl_cnt % 65536);
    if (mdl_busy) chk("m_data", m_data, mdl_word[8*mdl_pos +: 8]);
    if (hs) out_bytes.push_back(m_data);
    if (c) begin
      mdl_busy = 1'b0;
      mdl_pos  = 0;
    end else begin
      if (hs && exp_last) mdl_cnt++;
      if (exp_rd) begin
        mdl_word = fq.pop_front();
        mdl_busy = 1'b1;
        mdl_pos  = 0;
      end else if (hs) begin
        if (exp_last) mdl_busy = 1'b0;
        else mdl_pos++;
      end
    end
  endtask

  // Pull reset between clock edges and check outputs fall without an edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    fifo_empty = 1'b1;
    m_ready    = 1'b0;
    clr        = 1'b0;
    mdl_busy   = 1'b0;
    mdl_pos    = 0;
    mdl_cnt    = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int target;

    // Reset state, with a non-empty FIFO to show fifo_rd stays low.
    #1 rst_n = 1'b0;
    fifo_empty = 1'b0;
    fifo_dout  = 32'hDEADBEEF;
    #1;
    chk("init_m_valid", m_valid, 0);
    chk("init_m_last", m_last, 0);
    chk("init_m_data", m_data, 0);
    chk("init_word_cnt", word_cnt, 0);
    chk("init_fifo_rd", fifo_rd, 0);
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO for 20 cycles, then a single word.
    repeat (20) step(1'b1, 1'b0);
    fq.push_back(32'hC409F65A);
    repeat (6) step(1'b1, 1'b0);
    chk("single_cnt", word_cnt, 1);

    // Back-to-back words with no gap.
    fq.push_back(32'hC409F65A);
    fq.push_back(32'h7AA0E281);
    repeat (10) step(1'b1, 1'b0);
    chk("b2b_cnt", word_cnt, 3);

    // clr after F6 accepted, while byte 09 is stalled.
    fq.push_back(32'hC409F65A);
    fq.push_back(32'h11223344);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    chk("clr_cnt", word_cnt, 4);

    // clr coinciding with the final-byte handshake wins.
    fq.push_back(32'hA1B2C3D4);
    fq.push_back(32'h55667788);
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    chk("clr_last_cnt", word_cnt, 5);

    // Asynchronous reset after byte 09 is accepted.
    fq.push_back(32'hC409F65A);
    fq.push_back(32'h7AA0E281);
    repeat (4) step(1'b1, 1'b0);
    async_reset();
    repeat (6) step(1'b1, 1'b0);
    chk("post_rst_cnt", word_cnt, 1);

    // Randomized words and backpressure.
    out_bytes.delete();
    exp_bytes.delete();
    target = mdl_cnt + 1024;
    cyc = 0;
    for (int pushed = 0; mdl_cnt != target && cyc < 40000; cyc++) begin
      if (pushed < 1024 && $urandom_range(0, 3) != 0) begin
        logic [31:0] w;
        w = $urandom;
        fq.push_back(w);
        for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
        pushed++;
      end
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    chk("rand_timeout", (cyc < 40000), 1);
    step(1'b0, 1'b0);
    chk("rand_cnt", word_cnt, 1025);
    chk("rand_nbytes", out_bytes.size(), 4096);
    for (int i = 0; i < out_bytes.size() && i < exp_bytes.size(); i++)
      chk("rand_byte", out_bytes[i], exp_bytes[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
